// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, default taps, state encoding and accumulator sizing for the serial FIR.
package fir_pkg;
   localparam int DW = 16;
   localparam int FRAC = 14;
   localparam int NTAPS_DEF = 9;
   typedef enum logic [1:0] {IDLE, MAC, OUT, FLUSH} state_t;
   localparam logic [DW-1:0] DEF_COEF [NTAPS_DEF] = '{
      16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F, 16'h1496, 16'h1089, 16'h0AE4, 16'h04F6};
   function automatic int acc_w(input int ntaps);
      return 2*DW + $clog2(ntaps);
   endfunction
   // Only the 9-tap build has a meaningful default response; other sizes start from an all-zero bank.
   function automatic logic [DW-1:0] reset_coef(input int ntaps, input logic [3:0] i);
      return (ntaps == NTAPS_DEF && int'(i) < NTAPS_DEF) ? DEF_COEF[i] : '0;
   endfunction
endpackage

// File: rtl/fir_serial_seq_if.sv
// fir_serial_seq_if: sample stream, coefficient write port and flush/busy control for fir_serial_seq.
interface fir_serial_seq_if import fir_pkg::*; #(parameter int W = DW);
   logic in_valid, in_ready, out_valid, out_ready, coef_we, coef_ready, flush, busy;
   logic [W-1:0] in_data, out_data, coef_wdata;
   logic [3:0] coef_addr;
   modport master (output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
                   input in_ready, out_valid, out_data, coef_ready, busy);
   modport slave (input in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, flush,
                  output in_ready, out_valid, out_data, coef_ready, busy);
endinterface

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: clearable multiply-accumulate register with Q1.14 output slice.
// Define FIR_SATURATE_EN to clamp out-of-range results instead of wrapping.
module fir_mac_unit import fir_pkg::*; #(parameter int AW = 36) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic [DW-1:0]        res
);
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [2*DW-1:0] prod;
   always_comb begin
      prod = a * b;
      acc_d = clr ? '0 : en ? acc_q + AW'(prod) : acc_q;
   end
   always_ff @(posedge clk) acc_q <= !rst_n ? '0 : acc_d;
`ifdef FIR_SATURATE_EN
   logic ovf, unused_lsb;
   always_comb begin
      ovf = !(&acc_q[AW-1:FRAC+DW-1]) && (|acc_q[AW-1:FRAC+DW-1]);
      res = !ovf ? acc_q[FRAC+DW-1:FRAC] : acc_q[AW-1] ? {1'b1, {DW-1{1'b0}}} : {1'b0, {DW-1{1'b1}}};
   end
   assign unused_lsb = ^acc_q[FRAC-1:0];
`else
   logic unused_bits;
   assign res = acc_q[FRAC+DW-1:FRAC];
   assign unused_bits = ^{acc_q[AW-1:FRAC+DW], acc_q[FRAC-1:0]};
`endif
endmodule

// File: rtl/fir_serial_seq.sv
// fir_serial_seq: time-multiplexed FIR sequencer with one MAC, a circular delay line and a writable coefficient bank.
// Define FIR_SATURATE_EN to saturate the output instead of wrapping on overflow.
module fir_serial_seq import fir_pkg::*; #(parameter int NTAPS = NTAPS_DEF) (
   input logic             clk,
   input logic             rst_n,
   fir_serial_seq_if.slave bus
);
   localparam int AW = acc_w(NTAPS);
   localparam logic [3:0] LAST = 4'(NTAPS - 1);
   state_t state_q, state_d;
   logic [3:0] k_q, k_d, wr_ptr_q, wr_ptr_d, rd_idx;
   logic [DW-1:0] buf_q [NTAPS], buf_d [NTAPS], coef_q [NTAPS], coef_d [NTAPS];
   logic out_valid_q, out_valid_d, clr, en;
   logic [DW-1:0] mac_res;
   always_comb begin
      rd_idx = wr_ptr_q >= k_q ? wr_ptr_q - k_q : wr_ptr_q + 4'(NTAPS) - k_q;
      state_d = state_q;
      k_d = k_q;
      wr_ptr_d = wr_ptr_q;
      buf_d = buf_q;
      coef_d = coef_q;
      out_valid_d = out_valid_q;
      clr = 1'b0;
      en = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.coef_we && {1'b0, bus.coef_addr} < 5'(NTAPS)) coef_d[bus.coef_addr] = bus.coef_wdata;
            if (bus.flush) state_d = FLUSH;
            else if (bus.in_valid) begin
               buf_d[wr_ptr_q] = bus.in_data;
               clr = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            en = 1'b1;
            k_d = k_q == LAST ? '0 : k_q + 4'd1;
            if (k_q == LAST) begin
               wr_ptr_d = wr_ptr_q == LAST ? '0 : wr_ptr_q + 4'd1;
               out_valid_d = 1'b1;
               state_d = OUT;
            end
         end
         OUT: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d = IDLE;
         end
         FLUSH: begin
            buf_d[k_q] = '0;
            k_d = k_q == LAST ? '0 : k_q + 4'd1;
            if (k_q == LAST) begin
               wr_ptr_d = '0;
               state_d = IDLE;
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q <= '0;
         wr_ptr_q <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            buf_q[i] <= '0;
            coef_q[i] <= reset_coef(NTAPS, 4'(i));
         end
      end else begin
         state_q <= state_d;
         k_q <= k_d;
         wr_ptr_q <= wr_ptr_d;
         out_valid_q <= out_valid_d;
         buf_q <= buf_d;
         coef_q <= coef_d;
      end
   end
   fir_mac_unit #(.AW(AW)) u_mac (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
      .a(buf_q[rd_idx]), .b(coef_q[k_q]), .res(mac_res)
   );
   assign bus.in_ready = state_q == IDLE && !bus.flush;
   assign bus.coef_ready = state_q == IDLE;
   assign bus.busy = state_q != IDLE;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data = mac_res;
endmodule

// File: tb/tb_fir_serial_seq.sv
// tb_fir_serial_seq: table-driven and randomized checks of fir_serial_seq against a plain-arithmetic FIR model.
module tb_fir_serial_seq;
   localparam int N = 9;
   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int errors = 0, checks = 0;
   logic [15:0] taps [N] = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F, 16'h1496, 16'h1089, 16'h0AE4, 16'h04F6};
   logic [15:0] mbuf [N], mcoef [N];
   int mptr;
   vec_t imp [N];
   always #5 clk = ~clk;
   fir_serial_seq_if bus ();
   fir_serial_seq #(.NTAPS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic m_reset;
      for (int i = 0; i < N; i++) begin
         mbuf[i] = '0;
         mcoef[i] = taps[i];
      end
      mptr = 0;
   endtask

   // Direct convolution over the delay line with wide signed arithmetic, then Q1.14 rescale.
   function automatic logic [15:0] m_accept(input logic [15:0] x);
      logic signed [63:0] acc, s;
      logic signed [15:0] smp, cf;
      acc = 0;
      mbuf[mptr] = x;
      for (int k = 0; k < N; k++) begin
         smp = mbuf[(mptr - k + N) % N];
         cf = mcoef[k];
         acc += smp * cf;
      end
      mptr = (mptr + 1) % N;
      s = acc >>> 14;
`ifdef FIR_SATURATE_EN
      if (s > 64'sd32767) return 16'h7FFF;
      if (s < -64'sd32768) return 16'h8000;
`endif
      return s[15:0];
   endfunction

   task automatic send(input logic [15:0] x, input bit rr, input bit poke,
                       output logic [15:0] got, output logic [15:0] exp, output int lat);
      bit a, done;
      a = 0;
      done = 0;
      got = '0;
      lat = 0;
      bus.in_valid = 1'b1;
      bus.in_data = x;
      for (int i = 0; i < 40 && !a; i++) begin
         #1 a = bus.in_ready;
         tick;
      end
      bus.in_valid = 1'b0;
      exp = m_accept(x);
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready never seen, required 1");
         return;
      end
      for (int c = 1; c < 60 && !done; c++) begin
         bus.coef_we = poke && c <= 3;
         bus.coef_addr = 4'd4;
         bus.coef_wdata = 16'h1234;
         bus.out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (poke && c <= 3) check("mac_coef_ready", bus.coef_ready, 0);
         if (bus.out_valid && lat == 0) lat = c;
         if (bus.out_valid && bus.out_ready) begin
            got = bus.out_data;
            done = 1;
         end
         tick;
      end
      bus.coef_we = 1'b0;
      bus.out_ready = 1'b1;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL out_timeout: no output handshake, required one");
      end
   endtask

   task automatic wr_coef(input logic [3:0] ad, input logic [15:0] d);
      bus.coef_we = 1'b1;
      bus.coef_addr = ad;
      bus.coef_wdata = d;
      #1 check("coef_ready", bus.coef_ready, 1);
      tick;
      bus.coef_we = 1'b0;
      if (int'(ad) < N) mcoef[ad] = d;
   endtask

   task automatic do_flush(input bit with_valid);
      int c;
      bit ov;
      c = 0;
      ov = 0;
      bus.flush = 1'b1;
      bus.in_valid = with_valid;
      bus.in_data = 16'h4000;
      #1 check("flush_in_ready", bus.in_ready, 0);
      tick;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      while (bus.busy && c < 40) begin
         ov |= bus.out_valid;
         tick;
         c++;
      end
      check("flush_cycles", c, N);
      check("flush_no_out", ov, 0);
      for (int i = 0; i < N; i++) mbuf[i] = '0;
      mptr = 0;
   endtask

   task automatic run_impulse(input string nm);
      logic [15:0] got, exp;
      int lat;
      for (int i = 0; i < N; i++) begin
         send(imp[i].din, 0, 0, got, exp, lat);
         check({nm, "_data"}, got, imp[i].dout);
         check({nm, "_lat"}, lat, N + 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] got, exp, d0;
      logic [15:0] step9;
      int lat, r;
      bit a, ov;
`ifdef FIR_SATURATE_EN
      step9 = 16'h7FFF;
`else
      step9 = 16'h8001;
`endif
      for (int i = 0; i < N; i++) imp[i] = '{(i == 0) ? 16'h4000 : 16'h0000, taps[i]};
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      bus.coef_we = 1'b0;
      bus.coef_addr = '0;
      bus.coef_wdata = '0;
      bus.flush = 1'b0;
      m_reset();
      tick;
      tick;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", bus.busy, 0);
      #1 check("rst_in_ready", bus.in_ready, 1);
      check("rst_coef_ready", bus.coef_ready, 1);
      rst_n = 1'b1;
      run_impulse("impulse");

      for (int i = 0; i < N; i++) begin
         send(16'h4000, 0, 0, got, exp, lat);
         check("step_model", got, exp);
         if (i == N - 1) check("step_last", got, step9);
      end

      bus.in_valid = 1'b1;
      bus.in_data = 16'h2000;
      a = 0;
      for (int i = 0; i < 40 && !a; i++) begin
         #1 a = bus.in_ready;
         tick;
      end
      bus.out_ready = 1'b0;
      exp = m_accept(16'h2000);
      for (int i = 0; i < 40 && !bus.out_valid; i++) tick;
      d0 = bus.out_data;
      check("bp_data", d0, exp);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", bus.out_valid, 1);
         check("bp_stable", bus.out_data, d0);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_busy", bus.busy, 1);
         tick;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick;
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_idle", bus.busy, 0);

      do_flush(0);
      for (int i = 0; i < N; i++) wr_coef(4'(i), (i == 4) ? 16'h4000 : 16'h0000);
      wr_coef(4'd12, 16'h7777);
      for (int i = 0; i < N; i++) begin
         send((i == 0) ? 16'h4000 : 16'h0000, 0, i == 4, got, exp, lat);
         check("coef_imp", got, (i == 4) ? 16'h4000 : 16'h0000);
      end

      bus.in_valid = 1'b1;
      bus.in_data = 16'h4000;
      a = 0;
      for (int i = 0; i < 40 && !a; i++) begin
         #1 a = bus.in_ready;
         tick;
      end
      bus.in_valid = 1'b0;
      repeat (4) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      m_reset();
      ov = 0;
      repeat (15) begin
         ov |= bus.out_valid;
         tick;
      end
      check("rst_mid_no_out", ov, 0);
      check("rst_mid_idle", bus.busy, 0);
      run_impulse("impulse_after_rst");

      repeat (3) begin
         send(16'h4000, 0, 0, got, exp, lat);
         check("pre_flush", got, exp);
      end
      do_flush(1);
      run_impulse("impulse_after_flush");

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) do_flush(0);
         else if (r <= 2) wr_coef(4'($urandom_range(0, 15)), 16'($urandom));
         else begin
            send(16'($urandom), 1, 0, got, exp, lat);
            check("rand_data", got, exp);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
